// File: rtl/wb_burst_reader_pkg.sv
// wb_burst_reader_pkg: shared state encoding and Wishbone cycle-type constants
package wb_burst_reader_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone bus bundle carrying clock, reset and all cycle signals
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;
    logic        rty;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [2:0]  cti;
    logic [1:0]  bte;
    modport master (
        input  clk, rst, ack, err, rty, dat_sm,
        output cyc, stb, we, sel, adr, cti, bte, dat_ms
    );
    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, cti, bte, dat_ms,
        output ack, err, rty, dat_sm
    );
endinterface

// File: rtl/wb_reader_fifo.sv
// wb_reader_fifo: first-word-fall-through 32-bit FIFO buffering bus read data
module wb_reader_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        empty,
    output logic        full
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic do_push;
    logic do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign dout = empty ? 32'h0 : mem[rd_ptr];
    // pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    // storage array, no reset needed since reads are masked while empty
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/wb_burst_reader.sv
// wb_burst_reader: Wishbone master streaming a word block out through a FIFO (burst cycles with WB_BURST_READER_BURST_EN)
module wb_burst_reader
    import wb_burst_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH = 16
) (
    wshb_if.master               wb_m,
    input  logic                 start,
    input  logic [31:0]          base_adr,
    input  logic [LEN_WIDTH-1:0] length,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);
    state_t state;
    state_t state_nxt;
    logic [31:0] adr_q;
    logic [LEN_WIDTH-1:0] remaining;
    logic [LEN_WIDTH-1:0] pending;
    logic accept;
    logic beat;
    logic pop;
    logic empty;
    logic full;
    assign accept = state == IDLE && start;
    assign beat = wb_m.stb && wb_m.ack;
    assign pop = out_valid && out_ready;
    assign out_valid = !empty;
    assign wb_m.we = 1'b0;
    assign wb_m.sel = 4'b1111;
    assign wb_m.bte = 2'b00;
    assign wb_m.dat_ms = 32'h0;
    wb_reader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(wb_m.clk),
        .rst(wb_m.rst),
        .flush(accept),
        .push(beat),
        .din(wb_m.dat_sm),
        .pop(pop),
        .dout(out_data),
        .empty(empty),
        .full(full)
    );
    // state register
    always_ff @(posedge wb_m.clk or posedge wb_m.rst)
        if (wb_m.rst) state <= IDLE;
        else state <= state_nxt;
    // next state: finish reading on the last ack, finish draining on the pop of the last outstanding word
    always_comb begin
        state_nxt = state;
        if (accept && length != '0) state_nxt = READ;
        if (state == READ && beat && remaining == LEN_WIDTH'(1)) state_nxt = DRAIN;
        if (state == DRAIN && pop && pending == LEN_WIDTH'(1)) state_nxt = IDLE;
    end
    // bus outputs decoded from state; stb backs off while the FIFO is full
    always_comb begin
        wb_m.cyc = state == READ;
        wb_m.stb = state == READ && !full;
        wb_m.adr = adr_q;
        busy = state != IDLE;
`ifdef WB_BURST_READER_BURST_EN
        wb_m.cti = state != READ ? CTI_CLASSIC : (remaining == LEN_WIDTH'(1) ? CTI_END : CTI_INCR);
`else
        wb_m.cti = CTI_CLASSIC;
`endif
    end
    // address, beats left on the bus, words not yet consumed downstream, and the done pulse
    always_ff @(posedge wb_m.clk or posedge wb_m.rst)
        if (wb_m.rst) begin
            adr_q <= 32'h0;
            remaining <= '0;
            pending <= '0;
            done <= 1'b0;
        end else begin
            done <= (accept && length == '0) || (state == DRAIN && pop && pending == LEN_WIDTH'(1));
            if (accept) begin
                adr_q <= {base_adr[31:2], 2'b00};
                remaining <= length;
                pending <= length;
            end else begin
                if (beat) begin
                    adr_q <= adr_q + 32'd4;
                    remaining <= remaining - LEN_WIDTH'(1);
                end
                if (pop) pending <= pending - LEN_WIDTH'(1);
            end
        end
endmodule

// File: tb/tb_wb_burst_reader.sv
// tb_wb_burst_reader: directed checks of wb_burst_reader against a registered-read block RAM slave
module tb_wb_burst_reader;
    import wb_burst_reader_pkg::*;
    localparam int DEPTH = 8;
`ifdef WB_BURST_READER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] base_adr = 32'h0;
    logic [15:0] length = 16'h0;
    logic out_ready = 1'b1;
    logic busy;
    logic done;
    logic out_valid;
    logic [31:0] out_data;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    wshb_if wb (.clk(clk), .rst(rst));
    wb_burst_reader #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(16)) dut (
        .wb_m(wb),
        .start(start),
        .base_adr(base_adr),
        .length(length),
        .busy(busy),
        .done(done),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );
    logic [31:0] mem [256];
    logic ack_r;
    logic [31:0] rd_adr;
    initial for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
    assign rd_adr = (wb.ack && wb.cti == CTI_INCR) ? wb.adr + 32'd4 : wb.adr;
    assign wb.ack = ack_r && wb.cyc && wb.stb;
    assign wb.err = 1'b0;
    assign wb.rty = 1'b0;
    always @(posedge clk or posedge rst)
        if (rst) begin
            ack_r <= 1'b0;
            wb.dat_sm <= 32'h0;
        end else begin
            ack_r <= wb.cyc && wb.stb && (!wb.ack || wb.cti == CTI_INCR);
            wb.dat_sm <= mem[rd_adr[9:2]];
        end
    logic [31:0] ack_adr[$];
    logic [31:0] ack_cti[$];
    logic [31:0] got[$];
    int ack_cyc[$];
    int cyc_n = 0;
    int done_cnt = 0;
    int done_busy = 0;
    int done_at = 0;
    int last_pop = 0;
    bit cyc_seen = 1'b0;
    initial forever begin
        @(negedge clk);
        cyc_n++;
        if (!rst) begin
            if (wb.ack) begin
                ack_adr.push_back(wb.adr);
                ack_cti.push_back(32'(wb.cti));
                ack_cyc.push_back(cyc_n);
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                last_pop = cyc_n;
            end
            if (done) begin
                done_cnt++;
                done_at = cyc_n;
                if (busy) done_busy++;
            end
            if (wb.cyc) cyc_seen = 1'b1;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask
    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return i < q.size() ? q[i] : 32'hDEAD_BEEF;
    endfunction
    task automatic clear();
        ack_adr.delete();
        ack_cti.delete();
        ack_cyc.delete();
        got.delete();
        done_cnt = 0;
        done_busy = 0;
        cyc_seen = 1'b0;
    endtask
    task automatic kick(input logic [31:0] b, input logic [15:0] l);
        @(posedge clk);
        #1;
        base_adr = b;
        length = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask
    task automatic wait_done(input int limit);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask
    task automatic check_words(input string tag, input int n, input logic [31:0] a0, input logic [31:0] d0);
        check({tag, " count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s adr%0d", tag, i), qget(ack_adr, i), a0 + 32'(4 * i));
            check($sformatf("%s word%0d", tag, i), qget(got, i), d0 + 32'(i));
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst cyc", 32'(wb.cyc), 0);
        check("rst stb", 32'(wb.stb), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst valid", 32'(out_valid), 0);
        check("rst adr", wb.adr, 0);
        check("rst cti", 32'(wb.cti), 0);
        check("rst data", out_data, 0);
        rst = 1'b0;
        clear();
        kick(32'h10, 16'd4);
        check("A busy", 32'(busy), 1);
        check("A cyc", 32'(wb.cyc), 1);
        wait_done(100);
        check("A done", 32'(done_cnt), 1);
        check("A busy at done", 32'(done_busy), 0);
        check("A done lag", 32'(done_at - last_pop), 1);
        check_words("A", 4, 32'h10, 32'hA500_0004);
        for (int i = 0; i < 4; i++)
            check($sformatf("A cti%0d", i), qget(ack_cti, i), BURST ? (i == 3 ? 32'h7 : 32'h2) : 32'h0);
        for (int i = 1; i < 4; i++)
            check($sformatf("A gap%0d", i), 32'(i < ack_cyc.size() ? ack_cyc[i] - ack_cyc[i-1] : -1),
                  BURST ? 32'd1 : 32'd2);
        clear();
        out_ready = 1'b0;
        kick(32'h0, 16'd20);
        repeat (30) @(posedge clk);
        #1;
        check("B acks held", 32'(ack_adr.size()), DEPTH);
        check("B stb", 32'(wb.stb), 0);
        check("B cyc", 32'(wb.cyc), 1);
        check("B valid", 32'(out_valid), 1);
        check("B head", out_data, 32'hA500_0000);
        out_ready = 1'b1;
        wait_done(300);
        check("B done", 32'(done_cnt), 1);
        check_words("B", 20, 32'h0, 32'hA500_0000);
        clear();
        kick(32'h10, 16'd0);
        check("C done", 32'(done), 1);
        check("C busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        check("C done drop", 32'(done), 0);
        repeat (3) @(posedge clk);
        check("C cyc", 32'(cyc_seen), 0);
        check("C pulses", 32'(done_cnt), 1);
        clear();
        kick(32'h10, 16'd4);
        repeat (2) @(posedge clk);
        kick(32'h80, 16'd2);
        wait_done(100);
        repeat (20) @(posedge clk);
        check("D done", 32'(done_cnt), 1);
        check("D acks", 32'(ack_adr.size()), 4);
        check_words("D", 4, 32'h10, 32'hA500_0004);
        clear();
        kick(32'h40, 16'd6);
        for (int n = 0; n < 50 && got.size() < 2; n++) @(negedge clk);
        check("E two words", 32'(got.size() >= 2), 1);
        #2;
        rst = 1'b1;
        #1;
        check("E cyc", 32'(wb.cyc), 0);
        check("E stb", 32'(wb.stb), 0);
        check("E busy", 32'(busy), 0);
        check("E valid", 32'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        check("E no done", 32'(done_cnt), 0);
        clear();
        kick(32'h20, 16'd3);
        wait_done(100);
        check("E2 done", 32'(done_cnt), 1);
        check_words("E2", 3, 32'h20, 32'hA500_0008);
        clear();
        kick(32'hFFFF_FFFB, 16'd3);
        wait_done(100);
        check("F done", 32'(done_cnt), 1);
        check("F adr0", qget(ack_adr, 0), 32'hFFFF_FFF8);
        check("F adr1", qget(ack_adr, 1), 32'hFFFF_FFFC);
        check("F adr2", qget(ack_adr, 2), 32'h0000_0000);
        check("F word0", qget(got, 0), 32'hA500_00FE);
        check("F word1", qget(got, 1), 32'hA500_00FF);
        check("F word2", qget(got, 2), 32'hA500_0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
